// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered x/y counters with aligned de/hsync/vsync and
// combinational line/frame strobes. Optional macro PIXEL_DIV2_EN advances every 2nd clk.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_en,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be within 1..1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    // 11-bit window bounds so a 1024 boundary still compares correctly
    localparam logic [10:0] HA     = 11'(H_ACTIVE);
    localparam logic [10:0] VA     = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic       w_pix_en;
    logic [9:0] r_x, r_y;
    logic       r_de, r_hs, r_vs;
    logic [9:0] w_x_nxt, w_y_nxt;
    logic       w_de_nxt, w_hs_nxt, w_vs_nxt;

`ifdef PIXEL_DIV2_EN
    logic r_tog;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tog <= 1'b0;
        else     r_tog <= ~r_tog;
    end

    assign w_pix_en = r_tog;
`else
    assign w_pix_en = 1'b1;
`endif

    // Decode de/sync from next-state counters so they register alongside x/y
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_pix_en) begin
            if (r_x == H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == V_LAST) ? '0 : r_y + 10'd1;
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
        w_de_nxt = ({1'b0, w_x_nxt} < HA) && ({1'b0, w_y_nxt} < VA);
        w_hs_nxt = (({1'b0, w_x_nxt} >= HS_BEG) && ({1'b0, w_x_nxt} < HS_END)) ? SYNC_POL : ~SYNC_POL;
        w_vs_nxt = (({1'b0, w_y_nxt} >= VS_BEG) && ({1'b0, w_y_nxt} < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x  <= H_LAST;
            r_y  <= V_LAST;
            r_de <= 1'b0;
            r_hs <= ~SYNC_POL;
            r_vs <= ~SYNC_POL;
        end else begin
            r_x  <= w_x_nxt;
            r_y  <= w_y_nxt;
            r_de <= w_de_nxt;
            r_hs <= w_hs_nxt;
            r_vs <= w_vs_nxt;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign de          = r_de;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign pixel_en    = w_pix_en;
    assign line_start  = (r_x == 10'd0) && w_pix_en;
    assign frame_start = (r_x == 10'd0) && (r_y == 10'd0) && w_pix_en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny 16x8 raster with SYNC_POL=1.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_de, d_hs, d_vs, d_pe, d_ls, d_fs;
    logic s_de, s_hs, s_vs, s_pe, s_ls, s_fs;

    integer checks = 0;
    integer errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .rst(rst), .x(d_x), .y(d_y), .de(d_de), .hsync(d_hs), .vsync(d_vs),
        .pixel_en(d_pe), .line_start(d_ls), .frame_start(d_fs)
    );

    // H_TOTAL=16 (hsync x 10..12), V_TOTAL=8 (vsync y 5..6), frame = 128 clks
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst(rst), .x(s_x), .y(s_y), .de(s_de), .hsync(s_hs), .vsync(s_vs),
        .pixel_en(s_pe), .line_start(s_ls), .frame_start(s_fs)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (d_x !== 10'd799) begin errors++; $display("FAIL reset_x: got %0d expected 799", d_x); end
        checks++; if (d_y !== 10'd524) begin errors++; $display("FAIL reset_y: got %0d expected 524", d_y); end
        checks++; if (d_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", d_de); end
        checks++; if (d_hs !== 1'b1 || d_vs !== 1'b1) begin errors++; $display("FAIL reset_sync: got hs=%b vs=%b expected 1/1", d_hs, d_vs); end
        checks++; if (d_ls !== 1'b0 || d_fs !== 1'b0) begin errors++; $display("FAIL reset_strobes: got ls=%b fs=%b expected 0/0", d_ls, d_fs); end
        checks++; if (d_pe !== 1'b1) begin errors++; $display("FAIL reset_pixel_en: got %b expected 1", d_pe); end
        checks++; if (s_x !== 10'd15 || s_y !== 10'd7) begin errors++; $display("FAIL reset_small_xy: got %0d,%0d expected 15,7", s_x, s_y); end
        checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin errors++; $display("FAIL reset_pol1_sync: got hs=%b vs=%b expected 0/0", s_hs, s_vs); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (d_x !== 10'd0 || d_y !== 10'd0) begin errors++; $display("FAIL first_xy: got %0d,%0d expected 0,0", d_x, d_y); end
        checks++; if (d_de !== 1'b1) begin errors++; $display("FAIL first_de: got %b expected 1", d_de); end
        checks++; if (d_fs !== 1'b1 || d_ls !== 1'b1) begin errors++; $display("FAIL first_strobes: got fs=%b ls=%b expected 1/1", d_fs, d_ls); end
        @(negedge clk);
        checks++; if (d_x !== 10'd1) begin errors++; $display("FAIL second_x: got %0d expected 1", d_x); end
        checks++; if (d_fs !== 1'b0 || d_ls !== 1'b0) begin errors++; $display("FAIL second_strobes: got fs=%b ls=%b expected 0/0", d_fs, d_ls); end
    endtask

    task automatic test_line();
        int ex, ey;
        logic e_de, e_hs;
        do_reset();
        for (int k = 0; k <= 800; k++) begin
            @(negedge clk);
            ex = k % 800;
            ey = k / 800;
            e_de = (ex < 640);
            e_hs = !(ex >= 656 && ex < 752);
            checks++; if (d_x !== 10'(ex) || d_y !== 10'(ey)) begin errors++; $display("FAIL line_xy k=%0d: got %0d,%0d expected %0d,%0d", k, d_x, d_y, ex, ey); end
            checks++; if (d_de !== e_de) begin errors++; $display("FAIL line_de x=%0d: got %b expected %b", ex, d_de, e_de); end
            checks++; if (d_hs !== e_hs) begin errors++; $display("FAIL line_hsync x=%0d: got %b expected %b", ex, d_hs, e_hs); end
            checks++; if (d_vs !== 1'b1) begin errors++; $display("FAIL line_vsync x=%0d: got %b expected 1", ex, d_vs); end
            checks++; if (d_ls !== (ex == 0)) begin errors++; $display("FAIL line_start x=%0d: got %b expected %b", ex, d_ls, (ex == 0)); end
            checks++; if (d_fs !== (ex == 0 && ey == 0)) begin errors++; $display("FAIL line_frame_start x=%0d y=%0d: got %b expected %b", ex, ey, d_fs, (ex == 0 && ey == 0)); end
            checks++; if (d_pe !== 1'b1) begin errors++; $display("FAIL line_pixel_en x=%0d: got %b expected 1", ex, d_pe); end
        end
    endtask

    task automatic test_frame_pol1();
        int ex, ey, fs_count, last_fs, period;
        logic e_de, e_hs, e_vs;
        fs_count = 0;
        last_fs = -1;
        period = 0;
        do_reset();
        for (int n = 0; n <= 256; n++) begin
            @(negedge clk);
            ex = n % 16;
            ey = (n / 16) % 8;
            e_de = (ex < 8) && (ey < 4);
            e_hs = (ex >= 10 && ex < 13);
            e_vs = (ey >= 5 && ey < 7);
            checks++; if (s_x !== 10'(ex) || s_y !== 10'(ey)) begin errors++; $display("FAIL frame_xy n=%0d: got %0d,%0d expected %0d,%0d", n, s_x, s_y, ex, ey); end
            checks++; if (s_de !== e_de) begin errors++; $display("FAIL frame_de x=%0d y=%0d: got %b expected %b", ex, ey, s_de, e_de); end
            checks++; if (s_hs !== e_hs) begin errors++; $display("FAIL frame_hsync x=%0d: got %b expected %b", ex, s_hs, e_hs); end
            checks++; if (s_vs !== e_vs) begin errors++; $display("FAIL frame_vsync y=%0d: got %b expected %b", ey, s_vs, e_vs); end
            checks++; if (s_ls !== (ex == 0)) begin errors++; $display("FAIL frame_line_start x=%0d: got %b expected %b", ex, s_ls, (ex == 0)); end
            if (s_fs === 1'b1) begin
                fs_count++;
                if (last_fs >= 0) period = n - last_fs;
                last_fs = n;
            end
        end
        checks++; if (fs_count !== 3) begin errors++; $display("FAIL frame_start_count: got %0d expected 3", fs_count); end
        checks++; if (period !== 128) begin errors++; $display("FAIL frame_start_period: got %0d expected 128", period); end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        repeat (301) @(negedge clk);
        checks++; if (d_x !== 10'd300 || d_y !== 10'd0) begin errors++; $display("FAIL mid_pre_xy: got %0d,%0d expected 300,0", d_x, d_y); end
        checks++; if (s_x !== 10'd12 || s_y !== 10'd2) begin errors++; $display("FAIL mid_pre_small_xy: got %0d,%0d expected 12,2", s_x, s_y); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (d_x !== 10'd799 || d_y !== 10'd524) begin errors++; $display("FAIL mid_async_xy: got %0d,%0d expected 799,524", d_x, d_y); end
        checks++; if (d_de !== 1'b0 || d_hs !== 1'b1 || d_vs !== 1'b1) begin errors++; $display("FAIL mid_async_ctl: got de=%b hs=%b vs=%b expected 0/1/1", d_de, d_hs, d_vs); end
        checks++; if (s_x !== 10'd15 || s_y !== 10'd7 || s_de !== 1'b0) begin errors++; $display("FAIL mid_async_small: got %0d,%0d de=%b expected 15,7 de=0", s_x, s_y, s_de); end
        checks++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin errors++; $display("FAIL mid_async_pol1: got hs=%b vs=%b expected 0/0", s_hs, s_vs); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (d_x !== 10'd0 || d_y !== 10'd0 || d_fs !== 1'b1) begin errors++; $display("FAIL mid_restart: got %0d,%0d fs=%b expected 0,0 fs=1", d_x, d_y, d_fs); end
        checks++; if (s_x !== 10'd0 || s_y !== 10'd0 || s_fs !== 1'b1) begin errors++; $display("FAIL mid_restart_small: got %0d,%0d fs=%b expected 0,0 fs=1", s_x, s_y, s_fs); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame_pol1();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
